// File: rtl/fxp_add_sched.sv
// Round-robin scheduler sharing one saturating Q3.4 + Q2.3 -> Q3.1 adder among NREQ requesters.
// Optional saturation event counter enabled by defining FXP_SAT_CNT_EN.
module fxp_add_sched #(
    parameter int NREQ  = 4,
    parameter int ID_W  = $clog2(NREQ),
    parameter int CNT_W = 16
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [NREQ-1:0]     req_valid,
    output logic [NREQ-1:0]     req_ready,
    input  logic [NREQ*7-1:0]   req_a,
    input  logic [NREQ*5-1:0]   req_b,
    output logic                res_valid,
    input  logic                res_ready,
    output logic [3:0]          res_c,
    output logic [ID_W-1:0]     res_id,
    output logic                res_sat
`ifdef FXP_SAT_CNT_EN
    ,
    input  logic                sat_cnt_clr,
    output logic [CNT_W-1:0]    sat_cnt
`endif
);

    function automatic logic [ID_W-1:0] wrap_add(input logic [ID_W-1:0] base, input int off);
        int s;
        s = 32'(base) + off;
        if (s >= NREQ) s = s - NREQ;
        return ID_W'(s);
    endfunction

    logic [6:0]      a_arr [NREQ];
    logic [4:0]      b_arr [NREQ];

    generate
        for (genvar gi = 0; gi < NREQ; gi++) begin : g_unpack
            assign a_arr[gi] = req_a[7*gi +: 7];
            assign b_arr[gi] = req_b[5*gi +: 5];
        end
    endgenerate

    logic [ID_W-1:0] ptr_reg;
    logic            s1_valid_reg;
    logic [6:0]      s1_a_reg;
    logic [4:0]      s1_b_reg;
    logic [ID_W-1:0] s1_id_reg;
    logic            res_valid_reg;
    logic [3:0]      res_c_reg;
    logic [ID_W-1:0] res_id_reg;
    logic            res_sat_reg;

    logic            s2_load;
    logic            s1_load;
    logic [NREQ-1:0] grant;
    logic [ID_W-1:0] grant_id;
    logic [ID_W-1:0] cand;
    logic            grant_any;

    assign s2_load = !res_valid_reg || res_ready;
    assign s1_load = !s1_valid_reg || s2_load;

    // First valid requester at or after ptr, wrapping modulo NREQ.
    always_comb begin
        grant     = '0;
        grant_id  = ptr_reg;
        grant_any = 1'b0;
        cand      = ptr_reg;
        for (int k = 0; k < NREQ; k++) begin
            cand = wrap_add(ptr_reg, k);
            if (!grant_any && req_valid[cand]) begin
                grant[cand] = 1'b1;
                grant_id    = cand;
                grant_any   = 1'b1;
            end
        end
    end

    assign req_ready = grant & {NREQ{s1_load & ~rst}};

    logic [7:0] sum8;
    logic [4:0] r_next;
    logic       sat_next;
    logic [3:0] c_next;

    // Q4.4 sum, round half-up to Q3.1, clamp at 7.5.
    always_comb begin
        sum8     = {1'b0, s1_a_reg} + {2'b0, s1_b_reg, 1'b0};
        r_next   = 5'((sum8 + 8'd4) >> 3);
        sat_next = r_next > 5'd15;
        c_next   = sat_next ? 4'hF : r_next[3:0];
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ptr_reg       <= '0;
            s1_valid_reg  <= 1'b0;
            s1_a_reg      <= '0;
            s1_b_reg      <= '0;
            s1_id_reg     <= '0;
            res_valid_reg <= 1'b0;
            res_c_reg     <= '0;
            res_id_reg    <= '0;
            res_sat_reg   <= 1'b0;
        end else begin
            if (s2_load) begin
                res_valid_reg <= s1_valid_reg;
                if (s1_valid_reg) begin
                    res_c_reg   <= c_next;
                    res_id_reg  <= s1_id_reg;
                    res_sat_reg <= sat_next;
                end
            end
            if (s1_load) begin
                s1_valid_reg <= grant_any;
                if (grant_any) begin
                    s1_a_reg  <= a_arr[grant_id];
                    s1_b_reg  <= b_arr[grant_id];
                    s1_id_reg <= grant_id;
                    ptr_reg   <= wrap_add(grant_id, 1);
                end
            end
        end
    end

    assign res_valid = res_valid_reg;
    assign res_c     = res_c_reg;
    assign res_id    = res_id_reg;
    assign res_sat   = res_sat_reg;

`ifdef FXP_SAT_CNT_EN
    logic [CNT_W-1:0] sat_cnt_reg;

    always_ff @(posedge clk) begin
        if (rst || sat_cnt_clr) begin
            sat_cnt_reg <= '0;
        end else if (res_valid_reg && res_ready && res_sat_reg && !(&sat_cnt_reg)) begin
            sat_cnt_reg <= sat_cnt_reg + 1'b1;
        end
    end

    assign sat_cnt = sat_cnt_reg;
`endif

endmodule
